// File: rtl/vga_scandoubler_cfg.sv
// vga_scandoubler_cfg: 15 kHz RGB (pix_en strobed) to 31 kHz VGA line doubler; in clk/rst/pix_en/mode/colour/syncs, out colour/hsync/vsync/line_len/overflow
module vga_scandoubler_cfg #(
  parameter int CLKVIDEO    = 28000,
  parameter int CW          = 3,
  parameter int OW          = 6,
  parameter int LINEW       = 10,
  parameter int HSYNC_COUNT = int'((64'(CLKVIDEO) * 3360 * 2) / 1000000),
  parameter int VSYNC_COUNT = int'((64'(CLKVIDEO) * 114320 * 2) / 1000000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             enable_scandoubling,
  input  logic [1:0]       scan_mode,
  input  logic [CW-1:0]    ri,
  input  logic [CW-1:0]    gi,
  input  logic [CW-1:0]    bi,
  input  logic             hsync_ext_n,
  input  logic             vsync_ext_n,
  input  logic             csync_ext_n,
  output logic [OW-1:0]    ro,
  output logic [OW-1:0]    go,
  output logic [OW-1:0]    bo,
  output logic             hsync,
  output logic             vsync,
  output logic [LINEW-1:0] line_len,
  output logic             overflow
);
  localparam int VW = $clog2(VSYNC_COUNT + 1);
  logic [3*CW-1:0] mem_q [2**(LINEW+1)];
  logic [3*CW-1:0] rdata_q;
  logic [LINEW-1:0] wr_addr_q, rd_addr_q, line_len_q;
  logic hs_wr_q, wr_bank_q, wr_bank_d, overflow_q;
  logic hs_prev_q, rd_bank_q, phase_q, hs1_q, ph1_q;
  logic vs_prev_q, vs_arm_q, vs_act_q;
  logic [VW-1:0] vs_cnt_q;
  logic wr_fall, wr_sat, wr_en, rd_fall, rd_wrap;
  logic [1:0] sm;
  function automatic logic [CW-1:0] dim(input logic [CW-1:0] c, input logic [1:0] m);
    return m == 2'd1 ? c - (c >> 2) : m == 2'd2 ? c >> 1 : m == 2'd3 ? c >> 2 : c;
  endfunction
  function automatic logic [OW-1:0] expand(input logic [CW-1:0] c);
    logic [OW-1:0] e;
    e = '0;
    for (int i = 0; i < OW; i++) e[OW-1-i] = c[CW-1-(i%CW)];
    return e;
  endfunction
  assign wr_fall   = pix_en & hs_wr_q & ~hsync_ext_n;
  assign wr_sat    = &wr_addr_q;
  assign wr_en     = pix_en & ~wr_fall & ~wr_sat;
  assign wr_bank_d = wr_bank_q ^ wr_fall;
  assign rd_fall   = hs_prev_q & ~hsync_ext_n;
  assign rd_wrap   = (rd_addr_q == line_len_q) & hsync_ext_n & hs_prev_q;
  assign sm        = ph1_q ? scan_mode : 2'd0;
  assign line_len  = line_len_q;
  assign overflow  = overflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_wr_q    <= 1'b1;
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      line_len_q <= '1;
      overflow_q <= 1'b0;
    end else if (pix_en) begin
      hs_wr_q   <= hsync_ext_n;
      wr_bank_q <= wr_bank_d;
      if (wr_fall) begin
        line_len_q <= wr_addr_q;
        wr_addr_q  <= '0;
      end else if (!wr_sat) wr_addr_q <= wr_addr_q + 1'b1;
      else overflow_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_addr_q}] <= {ri, gi, bi};
    rdata_q <= mem_q[{rd_bank_q, rd_addr_q}];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_q <= 1'b1;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      phase_q   <= 1'b0;
      hs1_q     <= 1'b0;
      ph1_q     <= 1'b0;
    end else begin
      hs_prev_q <= hsync_ext_n;
      rd_addr_q <= (rd_fall | rd_wrap) ? '0 : rd_addr_q + 1'b1;
      if (rd_fall) rd_bank_q <= ~wr_bank_d;
      phase_q   <= rd_fall ? 1'b0 : rd_wrap ? ~phase_q : phase_q;
      hs1_q     <= int'(rd_addr_q) < HSYNC_COUNT;
      ph1_q     <= phase_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b1;
      vs_arm_q  <= 1'b1;
      vs_act_q  <= 1'b0;
      vs_cnt_q  <= '0;
    end else begin
      vs_prev_q <= vsync_ext_n;
      if (vs_act_q) begin
        vs_act_q <= int'(vs_cnt_q) != VSYNC_COUNT;
        vs_cnt_q <= int'(vs_cnt_q) == VSYNC_COUNT ? vs_cnt_q : vs_cnt_q + 1'b1;
      end else if (vs_arm_q && vs_prev_q && !vsync_ext_n) begin
        vs_act_q <= 1'b1;
        vs_arm_q <= 1'b0;
        vs_cnt_q <= VW'(1);
      end else if (vsync_ext_n) vs_arm_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ro    <= '0;
      go    <= '0;
      bo    <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (enable_scandoubling) begin
      ro    <= expand(dim(rdata_q[3*CW-1:2*CW], sm));
      go    <= expand(dim(rdata_q[2*CW-1:CW], sm));
      bo    <= expand(dim(rdata_q[CW-1:0], sm));
      hsync <= ~hs1_q;
      vsync <= ~vs_act_q;
    end else begin
      ro    <= expand(ri);
      go    <= expand(gi);
      bo    <= expand(bi);
      hsync <= csync_ext_n;
      vsync <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_scandoubler_cfg.sv
// tb_vga_scandoubler_cfg: scoreboard bench for the VGA scandoubler
module tb_vga_scandoubler_cfg;
  logic clk = 0, rst = 1, pix_en = 0, enable_scandoubling = 1;
  logic [1:0] scan_mode = 0;
  logic [2:0] ri = 0, gi = 0, bi = 0;
  logic hsync_ext_n = 1, vsync_ext_n = 1, csync_ext_n = 1;
  logic [5:0] ro, go, bo;
  logic hsync, vsync, overflow;
  logic [9:0] line_len;
  typedef struct {int cyc; int sel; int val;} exp_t;
  exp_t exp_q[$];
  int vs_exp[$];
  int cyc = 0, last_set = 0, checks = 0, errors = 0, vs_low = 0;
  string names [5] = '{"rgb", "hsync", "vsync", "line_len", "overflow"};
  vga_scandoubler_cfg dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .enable_scandoubling(enable_scandoubling),
    .scan_mode(scan_mode), .ri(ri), .gi(gi), .bi(bi),
    .hsync_ext_n(hsync_ext_n), .vsync_ext_n(vsync_ext_n), .csync_ext_n(csync_ext_n),
    .ro(ro), .go(go), .bo(bo), .hsync(hsync), .vsync(vsync),
    .line_len(line_len), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int dut_val(input int s);
    return s == 0 ? int'({ro, go, bo}) : s == 1 ? int'(hsync) : s == 2 ? int'(vsync) :
           s == 3 ? int'(line_len) : int'(overflow);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    int act;
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      act = dut_val(e.sel);
      checks++;
      if (e.cyc != cyc || act != e.val) begin
        errors++;
        $display("FAIL %s at cycle %0d (now %0d): got %0d, expected %0d", names[e.sel], e.cyc, cyc, act, e.val);
      end
    end
  end
  always @(negedge clk) begin
    if (vsync === 1'b0) vs_low++;
    else if (vs_low != 0) begin
      checks++;
      if (vs_exp.size() == 0) begin
        errors++;
        $display("FAIL vsync_width: got unexpected pulse of %0d clk, expected none", vs_low);
      end else begin
        if (vs_exp[0] != vs_low) begin
          errors++;
          $display("FAIL vsync_width: got %0d clk, expected %0d", vs_low, vs_exp[0]);
        end
        void'(vs_exp.pop_front());
      end
      vs_low = 0;
    end
  end
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout at cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end
  task automatic push(input int c, input int s, input int v);
    exp_q.push_back('{cyc: c, sel: s, val: v});
  endtask
  task automatic pix(input logic hs, input logic [8:0] col);
    @(posedge clk);
    #1;
    last_set = cyc;
    pix_en = 1;
    hsync_ext_n = hs;
    {ri, gi, bi} = col;
    @(posedge clk);
    #1;
    pix_en = 0;
  endtask
  task automatic line(input int n, input logic [8:0] col, input logic [1:0] m, input int chk,
                      input int p0, input int p1, input int ll, input int ov);
    int e;
    scan_mode = m;
    for (int k = 0; k < n; k++) begin
      pix(k < 32 ? 1'b0 : 1'b1, col);
      if (k == 0 && chk != 0) begin
        e = last_set + 1;
        push(e + 2, 1, 0);
        push(e + 10, 3, ll);
        push(e + 10, 4, ov);
        push(e + 102, 0, p0);
        if (chk == 1) begin
          push(e + 189, 1, 0);
          push(e + 190, 1, 1);
          push(e + 300, 2, 1);
          push(e + 450, 1, 0);
          push(e + 550, 0, p1);
          push(e + 637, 1, 0);
          push(e + 638, 1, 1);
        end else begin
          push(e + 450, 1, 1);
          push(e + 550, 0, p1);
        end
      end
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    pix_en = 0;
    push(cyc + 1, 0, 0);
    push(cyc + 1, 1, 1);
    push(cyc + 1, 2, 1);
    push(cyc + 1, 3, 1023);
    push(cyc + 1, 4, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic byp(input logic cs, input logic [8:0] col, input int exp_rgb);
    @(posedge clk);
    #1;
    enable_scandoubling = 0;
    csync_ext_n = cs;
    {ri, gi, bi} = col;
    push(cyc + 1, 0, exp_rgb);
    push(cyc + 1, 1, int'(cs));
    push(cyc + 1, 2, 1);
  endtask
  task automatic vs_pulse(input int low_clk);
    int c;
    @(posedge clk);
    #1;
    c = cyc;
    vsync_ext_n = 0;
    vs_exp.push_back(6401);
    push(c + 2, 2, 0);
    push(c + 6402, 2, 0);
    push(c + 6403, 2, 1);
    if (low_clk > 15000) push(c + 15000, 2, 1);
    repeat (low_clk) @(posedge clk);
    #1;
    vsync_ext_n = 1;
    repeat (10) @(posedge clk);
  endtask
  initial begin
    do_reset();
    repeat (4) pix(1'b1, 9'o000);
    line(448, 9'o752, 2'd1, 0, 0, 0, 0, 0);
    line(448, 9'o752, 2'd1, 1, {6'd63, 6'd45, 6'd18}, {6'd54, 6'd36, 6'd18}, 447, 0);
    line(448, 9'o361, 2'd2, 1, {6'd63, 6'd45, 6'd18}, {6'd27, 6'd18, 6'd9}, 447, 0);
    line(448, 9'o444, 2'd0, 1, {6'd27, 6'd54, 6'd9}, {6'd27, 6'd54, 6'd9}, 447, 0);
    line(448, 9'o444, 2'd3, 1, {6'd36, 6'd36, 6'd36}, {6'd9, 6'd9, 6'd9}, 447, 0);
    line(1100, 9'o615, 2'd3, 0, 0, 0, 0, 0);
    line(448, 9'o222, 2'd1, 2, {6'd54, 6'd9, 6'd45}, {6'd54, 6'd9, 6'd45}, 1023, 1);
    line(448, 9'o111, 2'd2, 1, {6'd18, 6'd18, 6'd18}, {6'd9, 6'd9, 6'd9}, 447, 1);
    byp(1'b0, 9'o536, {6'd45, 6'd27, 6'd54});
    byp(1'b1, 9'o270, {6'd18, 6'd63, 6'd0});
    byp(1'b0, 9'o147, {6'd9, 6'd36, 6'd63});
    byp(1'b1, 9'o555, {6'd45, 6'd45, 6'd45});
    @(posedge clk);
    #1;
    enable_scandoubling = 1;
    csync_ext_n = 1;
    vs_pulse(20000);
    vs_pulse(7000);
    line(448, 9'o555, 2'd0, 0, 0, 0, 0, 0);
    line(200, 9'o555, 2'd0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (4) pix(1'b1, 9'o000);
    line(448, 9'o123, 2'd3, 0, 0, 0, 0, 0);
    line(448, 9'o000, 2'd3, 1, {6'd9, 6'd18, 6'd27}, 0, 447, 0);
    repeat (20) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_checks: got %0d left, expected 0", exp_q.size());
    end
    checks++;
    if (vs_exp.size() != 0) begin
      errors++;
      $display("FAIL pending_vsync: got %0d pulses missing, expected 0", vs_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
